// File: rtl/mag_comp_seq_pkg.sv
// Shared types and sizing helpers for the digit-serial magnitude comparator.
package mag_comp_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DIGIT = 4;

    // ceil(log2(width/digit)), never below 1, so idx can always hold N-1
    function automatic int idx_width(input int width, input int digit);
        int n;
        int w;
        n = width / digit;
        w = 1;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mag_comp_digit.sv
// Combinational single-digit unsigned comparator; equality is neither gt nor lt.
module mag_comp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             gt,
    output logic             lt
);

    assign gt = (x > y);
    assign lt = (x < y);

endmodule

// File: rtl/mag_comp_seq.sv
// Digit-serial magnitude comparator: resolves MSB digit first and exits at the
// first differing digit. Handshake: start is sampled only in IDLE; done pulses
// for one cycle when the registered flags update; busy is high in RUN only.
module mag_comp_seq
    import mag_comp_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output state_t           dbg_state
);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $fatal(1, "mag_comp_seq: WIDTH must be a positive multiple of DIGIT");
    end

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = idx_width(WIDTH, DIGIT);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t           state, state_d;
    logic [IW-1:0]    idx, idx_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sm_q;
    logic             load;
    logic             done_d, eq_d, gt_d, lt_d;
    logic [WIDTH-1:0] a_ob, b_ob;
    logic [DIGIT-1:0] dig_a, dig_b;
    logic             dig_gt, dig_lt;

    // Signed compare becomes unsigned once the sign bit is flipped (offset binary)
    assign a_ob = a_q ^ (sm_q ? MSB_MASK : '0);
    assign b_ob = b_q ^ (sm_q ? MSB_MASK : '0);

    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                dig_a = a_ob[i*DIGIT +: DIGIT];
                dig_b = b_ob[i*DIGIT +: DIGIT];
            end
        end
    end

    mag_comp_digit #(.DIGIT(DIGIT)) u_digit (
        .x  (dig_a),
        .y  (dig_b),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    always_comb begin
        state_d = state;
        idx_d   = idx;
        load    = 1'b0;
        done_d  = 1'b0;
        eq_d    = a_eq_b;
        gt_d    = a_gt_b;
        lt_d    = a_lt_b;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_d   = IW'(N - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dig_gt || dig_lt) begin
                    gt_d    = dig_gt;
                    lt_d    = dig_lt;
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx == '0) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx - IW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sm_q   <= 1'b0;
            done   <= 1'b0;
            a_eq_b <= 1'b0;
            a_gt_b <= 1'b0;
            a_lt_b <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            done   <= done_d;
            a_eq_b <= eq_d;
            a_gt_b <= gt_d;
            a_lt_b <= lt_d;
            if (load) begin
                a_q  <= a;
                b_q  <= b;
                sm_q <= signed_mode;
            end
        end
    end

    assign busy      = (state == RUN);
    assign dbg_state = state;

endmodule

// File: doc/mag_comp_seq.md
# mag_comp_seq

Parametrised sequential magnitude comparator for WIDTH-bit operands. It resolves the result DIGIT bits per cycle, most significant digit first, and stops early at the first differing digit. It supports unsigned and two's-complement signed comparison and uses a start/busy/done handshake. The datapath and branch-compare logic use it where a full-width single-cycle comparator is too wide for timing.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle. The digit count is N = WIDTH/DIGIT, with N ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; asynchronous, active-low.
- start  input  1  request a comparison; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare; 0 = unsigned. Latched with the operands.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result flags update.
- a_eq_b  output  1  A equal to B; registered and held until the next done.
- a_gt_b  output  1  A greater than B; registered and held.
- a_lt_b  output  1  A less than B; registered and held.

## Operation
- FSM has two states, IDLE and RUN. Reset enters IDLE.
- IDLE with start=1:
  - latch a, b and signed_mode into internal registers
  - set digit index idx = N-1
  - go to RUN; busy=1 from the next cycle.
- IDLE with start=0: hold; flags keep their last value.
- Each RUN cycle compares digit idx of the latched A and B with the combinational digit comparator.
- Signed mode:
  - the top digit (idx = N-1) is compared with bit WIDTH-1 of both operands inverted (offset-binary)
  - lower digits are compared unsigned
  - unsigned mode compares every digit unsigned.
- Digits differ: set a_gt_b/a_lt_b accordingly, clear a_eq_b, pulse done, return to IDLE.
- Digits equal and idx=0: set a_eq_b=1, clear the other two flags, pulse done, return to IDLE.
- Digits equal and idx>0: idx decrements; stay in RUN.
- start in RUN, including the cycle done is asserted, is ignored. The next start is accepted in the first IDLE cycle.
- Changes on a, b or signed_mode during RUN do not affect the result.
- After the first done, exactly one flag is high.
- idx is a counter of ceil(log2(N)) bits, minimum 1. It never wraps, because RUN exits at idx=0.

## Timing
- Reset values: busy=0, done=0, a_eq_b=0, a_gt_b=0, a_lt_b=0, idx=0, state IDLE. All flags low means no valid result.
- rst_n asserted mid-RUN aborts immediately:
  - no done pulse
  - all outputs go to their reset values asynchronously.
- start accepted at edge E0.
- The first differing digit is the j-th from the MSB (j = 1..N), or j = N if the operands are equal.
- done and the flags become valid after edge E0+j. Latency is 1 cycle minimum and N cycles maximum.
- busy is high from after E0 until after E0+j; done and busy never overlap.
- Throughput: back-to-back starts give one result per j+1 cycles.
- N=1 (DIGIT=WIDTH): every compare takes 1 cycle. This is functionally a registered single-cycle comparator.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE=1'b0, RUN=1'b1)
  - the digit-count helper function used to size idx
  - default WIDTH/DIGIT constants for datapath instantiation.
- Sub-module mag_comp_digit: combinational DIGIT-bit comparator.
  - ports: x, y → gt, lt; eq is implied by neither being set
  - one instance, fed by a mux selecting digit idx from the latched operands.
- Elaboration-time check: WIDTH % DIGIT == 0, otherwise a fatal error.

## Test plan
Tests 1–5 use WIDTH=16, DIGIT=4 (N=4).
1. Unsigned, a=16'hD000, b=16'h8000 → done 1 cycle after start; a_gt_b=1, others 0.
2. Unsigned, a=b=16'h1234 → done 4 cycles after start; a_eq_b=1. busy is high for exactly 4 cycles.
3. Unsigned, a=16'h1235, b=16'h1236 → done after 4 cycles, a_lt_b=1. Then a=16'hFFFF, b=16'h0001: signed_mode=1 gives a_lt_b=1 after 1 cycle; signed_mode=0 gives a_gt_b=1 after 1 cycle.
4. Start accepted with a=16'h0500, b=16'h0400. Next cycle, drive start=1, a=0, b=16'hFFFF → the second start is ignored; done after 2 cycles with a_gt_b=1. The next start in IDLE is accepted.
5. Start, then rst_n low during the 2nd RUN cycle → all outputs 0 immediately, no done. After release, a fresh compare completes normally.
6. WIDTH=8, DIGIT=8: sweep all 256×256 pairs in both modes against a reference model → every result has 1-cycle latency and the correct single flag.
